transform_scheduler: RTL

TRANSFORM_SCHEDULER -- requirements
Module: transform_scheduler

---
 rtl/transform_scheduler.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/transform_scheduler.sv
// Transform scheduler: round-robin arbitration of two vertex requesters onto a
// single in-order transform datapath, tagging each issue with its requester and
// buffering returned results behind a credit-limited occupancy count.
module transform_scheduler #(
    parameter int DEPTH    = 8,
    parameter int PIPE_LAT = 0
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic [47:0]            req0_f,
    input  logic [15:0]            req0_w,
    output logic                   req0_ready,
    input  logic                   req1_valid,
    input  logic [47:0]            req1_f,
    input  logic [15:0]            req1_w,
    output logic                   req1_ready,
    output logic [47:0]            pipe_f,
    output logic [15:0]            pipe_w,
    output logic                   pipe_valid,
    input  logic [47:0]            pipe_result,
    input  logic                   pipe_result_valid,
    output logic                   out_valid,
    output logic [47:0]            out_data,
    output logic                   out_id,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   tag_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
    // Result entry layout: {counted, id, data}
    localparam int RW = 50;

    // The datapath latency is documentation only; the scheduler relies solely
    // on results coming back in issue order.
    if (PIPE_LAT < 0) begin : g_latNote
    end

    logic              r_lastGrant;
    logic [OW-1:0]     r_occ;
    logic              r_pipeValid;
    logic [47:0]       r_pipeF;
    logic [15:0]       r_pipeW;
    logic              r_tagErr;

    logic              r_tagMem [DEPTH];
    logic [AW:0]       r_tagWr;
    logic [AW:0]       r_tagRd;

    logic [RW-1:0]     r_resMem [DEPTH];
    logic [AW:0]       r_resWr;
    logic [AW:0]       r_resRd;

    logic              w_grantId;
    logic              w_anyValid;
    logic              w_hasCredit;
    logic              w_accept;
    logic              w_tagEmpty;
    logic              w_tagFull;
    logic              w_tagPush;
    logic              w_tagPop;
    logic              w_resEmpty;
    logic              w_resFull;
    logic              w_resPush;
    logic              w_resPop;
    logic              w_headCounted;
    logic              w_popCredit;
    logic              w_dropCredit;
    logic              w_tagFault;
    logic              w_inId;
    logic [RW-1:0]     w_resHead;
    logic [RW-1:0]     w_resEntry;
    logic [OW-1:0]     w_occNext;

    // FIFO status: equal indices with differing wrap bits means full.
    assign w_tagEmpty = (r_tagWr == r_tagRd);
    assign w_tagFull  = (r_tagWr[AW] != r_tagRd[AW]) &&
                        (r_tagWr[AW-1:0] == r_tagRd[AW-1:0]);
    assign w_resEmpty = (r_resWr == r_resRd);
    assign w_resFull  = (r_resWr[AW] != r_resRd[AW]) &&
                        (r_resWr[AW-1:0] == r_resRd[AW-1:0]);

    // Head of the result FIFO drives the output directly (first-word fall-through).
    assign w_resHead     = r_resMem[r_resRd[AW-1:0]];
    assign w_headCounted = w_resHead[49];
    assign out_valid     = !w_resEmpty;
    assign out_id        = w_resHead[48];
    assign out_data      = w_resHead[47:0];
    assign w_resPop      = out_valid && out_ready;

    // Only results that were issued through an accept hold a credit; orphan
    // results flagged as tag errors are buffered but never counted.
    assign w_popCredit  = w_resPop && w_headCounted;
    assign w_hasCredit  = (r_occ < DEPTH_C) || w_popCredit;

    // Round-robin choice: on contention favour the requester not granted last.
    always_comb begin
        w_grantId = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grantId = ~r_lastGrant;
        end else if (req1_valid) begin
            w_grantId = 1'b1;
        end
    end

    // Ready is gated by reset so nothing is accepted while reset is held.
    assign w_anyValid = req0_valid || req1_valid;
    assign w_accept   = rst && w_anyValid && w_hasCredit;
    assign req0_ready = w_accept && !w_grantId;
    assign req1_ready = w_accept &&  w_grantId;

    // Tag bookkeeping for returning results.
    assign w_tagPush  = w_accept && !w_tagFull;
    assign w_tagPop   = pipe_result_valid && !w_tagEmpty;
    assign w_inId     = w_tagEmpty ? 1'b0 : r_tagMem[r_tagRd[AW-1:0]];
    assign w_resEntry = {!w_tagEmpty, w_inId, pipe_result};
    assign w_resPush  = pipe_result_valid && !w_resFull;

    // A counted result dropped on overflow still returns its credit.
    assign w_dropCredit = pipe_result_valid && w_resFull && !w_tagEmpty;
    assign w_tagFault   = pipe_result_valid && (w_tagEmpty || w_resFull);

    assign w_occNext = r_occ + OW'(w_accept) - OW'(w_popCredit) - OW'(w_dropCredit);

    assign pipe_valid = r_pipeValid;
    assign pipe_f     = r_pipeF;
    assign pipe_w     = r_pipeW;
    assign occupancy  = r_occ;
    assign tag_err    = r_tagErr;

    // Register the granted vertex toward the datapath with a one-cycle strobe.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_pipeValid <= 1'b0;
            r_pipeF     <= '0;
            r_pipeW     <= '0;
        end else begin
            r_pipeValid <= w_accept;
            if (w_accept) begin
                r_pipeF <= w_grantId ? req1_f : req0_f;
                r_pipeW <= w_grantId ? req1_w : req0_w;
            end
        end
    end

    // Remember the last winner; it only moves when a vertex is actually taken.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_lastGrant <= 1'b1;
        end else if (w_accept) begin
            r_lastGrant <= w_grantId;
        end
    end

    // Occupancy tracks issued-but-not-yet-consumed vertices.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occNext;
        end
    end

    // Sticky error: orphan result or result arriving into a full buffer.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_tagErr <= 1'b0;
        end else if (w_tagFault) begin
            r_tagErr <= 1'b1;
        end
    end

    // Tag FIFO pointers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_tagWr <= '0;
            r_tagRd <= '0;
        end else begin
            if (w_tagPush) begin
                r_tagWr <= r_tagWr + 1'b1;
            end
            if (w_tagPop) begin
                r_tagRd <= r_tagRd + 1'b1;
            end
        end
    end

    // Tag FIFO storage; contents are irrelevant while the pointers say empty.
    always_ff @(posedge clk_in) begin
        if (w_tagPush) begin
            r_tagMem[r_tagWr[AW-1:0]] <= w_grantId;
        end
    end

    // Result FIFO pointers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_resWr <= '0;
            r_resRd <= '0;
        end else begin
            if (w_resPush) begin
                r_resWr <= r_resWr + 1'b1;
            end
            if (w_resPop) begin
                r_resRd <= r_resRd + 1'b1;
            end
        end
    end

    // Result FIFO storage.
    always_ff @(posedge clk_in) begin
        if (w_resPush) begin
            r_resMem[r_resWr[AW-1:0]] <= w_resEntry;
        end
    end

endmodule
